// File: rtl/ps2_key_event_decoder_if.sv
// Byte-stream input and key-event output handshakes of the PS/2 key event decoder.
// The master is the system side: it drives scan bytes in and pops events out.
interface ps2_key_event_decoder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [3:0] evt_mods;

  modport master (
    output in_valid, in_data, evt_ready,
    input  in_ready, evt_valid, evt_code, evt_ext, evt_brk, evt_mods
  );

  modport slave (
    input  in_valid, in_data, evt_ready,
    output in_ready, evt_valid, evt_code, evt_ext, evt_brk, evt_mods
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 parser: prefix decoding, modifier and caps tracking,
// typematic repeat filtering, and an event FIFO drained by the CPU side.
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_FILTER = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_key_event_decoder_if.slave bus,
  output logic [3:0]           mods,
  output logic                 key_held,
  output logic [CNT_W-1:0]     rel_cnt,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_SKIP    = 3'd4;

  // Modifier bit order: lshift, rshift, lctrl, rctrl, lalt, ralt (bit 0 first).
  localparam logic [47:0] MOD_CODES = {8'h11, 8'h11, 8'h14, 8'h14, 8'h59, 8'h12};
  localparam logic [5:0]  MOD_EXT   = 6'b101000;

  logic [2:0]       state_q, state_d;
  logic [2:0]       skip_cnt_q, skip_cnt_d;
  logic [5:0]       mod_q, mod_d, mod_hit;
  logic             caps_q, caps_d;
  logic [7:0]       last_code_q, last_code_d;
  logic             last_ext_q, last_ext_d;
  logic             last_valid_q, last_valid_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [13:0]      mem_q [FIFO_DEPTH];

  logic       accept, emit, ev_ext, ev_brk, is_repeat, take, push, pop;
  logic [3:0] mods_d;
  logic [13:0] head;

  assign bus.in_ready = (count_q != FULL_CNT);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    emit       = 1'b0;
    ev_ext     = 1'b0;
    ev_brk     = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          case (bus.in_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d    = S_SKIP;
              skip_cnt_d = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = S_IDLE;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          if (bus.in_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (bus.in_data != 8'hE0) begin
            emit    = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          emit    = 1'b1;
          ev_brk  = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          emit    = 1'b1;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
          state_d = S_IDLE;
        end
        S_SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A filtered repeat is dropped before any side effect, caps included.
  assign is_repeat = (REPEAT_FILTER != 0) && !ev_brk && last_valid_q &&
                     (last_ext_q == ev_ext) && (last_code_q == bus.in_data);
  assign take = emit & ~is_repeat;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mod
      assign mod_hit[gi] = take && (bus.in_data == MOD_CODES[gi*8 +: 8]) &&
                           (ev_ext == MOD_EXT[gi]);
      assign mod_d[gi]   = mod_hit[gi] ? ~ev_brk : mod_q[gi];
    end
  endgenerate

  assign caps_d = caps_q ^ (take & ~ev_brk & ~ev_ext & (bus.in_data == 8'h58));
  assign mods_d = {caps_d, mod_d[5] | mod_d[4], mod_d[3] | mod_d[2], mod_d[1] | mod_d[0]};

  always_comb begin
    last_code_d  = last_code_q;
    last_ext_d   = last_ext_q;
    last_valid_d = last_valid_q;
    if (take && !ev_brk) begin
      last_code_d  = bus.in_data;
      last_ext_d   = ev_ext;
      last_valid_d = 1'b1;
    end else if (take && ev_brk && last_ext_q == ev_ext && last_code_q == bus.in_data) begin
      last_valid_d = 1'b0;
    end
  end

  assign rel_cnt_d  = (take & ev_brk) ? rel_cnt_q + CNT_W'(1) : rel_cnt_q;
  assign overflow_d = overflow_q | (bus.in_valid & ~bus.in_ready);

  assign push     = take;
  assign pop      = bus.evt_ready & bus.evt_valid;
  assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      skip_cnt_q   <= '0;
      mod_q        <= '0;
      caps_q       <= 1'b0;
      last_code_q  <= '0;
      last_ext_q   <= 1'b0;
      last_valid_q <= 1'b0;
      rel_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      mod_q        <= mod_d;
      caps_q       <= caps_d;
      last_code_q  <= last_code_d;
      last_ext_q   <= last_ext_d;
      last_valid_q <= last_valid_d;
      rel_cnt_q    <= rel_cnt_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage is not reset; the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {mods_d, ev_ext, ev_brk, bus.in_data};
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_code  = bus.evt_valid ? head[7:0]   : 8'h00;
  assign bus.evt_brk   = bus.evt_valid ? head[8]     : 1'b0;
  assign bus.evt_ext   = bus.evt_valid ? head[9]     : 1'b0;
  assign bus.evt_mods  = bus.evt_valid ? head[13:10] : 4'h0;

  assign mods     = {caps_q, mod_q[5] | mod_q[4], mod_q[3] | mod_q[2], mod_q[1] | mod_q[0]};
  assign key_held = last_valid_q;
  assign rel_cnt  = rel_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder with default parameters.
// Event words are {valid, mods, ext, brk, code}.
module tb_ps2_key_event_decoder;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mods;
  logic       key_held;
  logic [7:0] rel_cnt;
  logic       overflow;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  ps2_key_event_decoder_if bus ();

  ps2_key_event_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .mods     (mods),
    .key_held (key_held),
    .rel_cnt  (rel_cnt),
    .overflow (overflow)
  );

  function automatic logic [14:0] ev(input logic [3:0] m, input logic e, input logic b,
                                     input logic [7:0] c);
    return {1'b1, m, e, b, c};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h in_ready=%b required=1", b, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic pop_evt(output logic [14:0] w);
    w = {bus.evt_valid, bus.evt_mods, bus.evt_ext, bus.evt_brk, bus.evt_code};
    bus.evt_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.in_ready, bus.evt_valid, mods, key_held, rel_cnt, overflow} !== 16'h8000) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b mods=%b held=%b rel=%h ovf=%b required rdy=1 rest 0",
               bus.in_ready, bus.evt_valid, mods, key_held, rel_cnt, overflow);
    end
    checks++;
    if ({bus.evt_code, bus.evt_ext, bus.evt_brk, bus.evt_mods} !== 14'h0) begin
      failures++;
      $display("FAIL reset_head got code=%h ext=%b brk=%b mods=%b required 0",
               bus.evt_code, bus.evt_ext, bus.evt_brk, bus.evt_mods);
    end
  endtask

  task automatic test_basic();
    logic [14:0] w;
    logic [14:0] exp [2];
    exp = '{ev(4'h0, 1'b0, 1'b0, 8'h1C), ev(4'h0, 1'b0, 1'b1, 8'h1C)};
    do_reset();
    send_byte(8'h1C);
    checks++;
    if (bus.evt_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency evt_valid=%b required=1", bus.evt_valid);
    end
    send_seq('{8'hF0, 8'h1C});
    checks++;
    if (rel_cnt !== 8'd1) begin
      failures++;
      $display("FAIL basic_rel_cnt got=%0d required=1", rel_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      pop_evt(w);
      checks++;
      if (w !== exp[i]) begin
        failures++;
        $display("FAIL basic_evt%0d got=%h required=%h", i, w, exp[i]);
      end
    end
  endtask

  task automatic test_repeat_filter();
    logic [14:0] w;
    logic [14:0] exp [4];
    exp = '{ev(4'h1, 1'b0, 1'b0, 8'h12), ev(4'h1, 1'b0, 1'b0, 8'h1C),
            ev(4'h1, 1'b0, 1'b1, 8'h1C), ev(4'h0, 1'b0, 1'b1, 8'h12)};
    do_reset();
    send_seq('{8'h12, 8'h1C, 8'h1C, 8'h1C});
    checks++;
    if ({key_held, mods} !== 5'b10001) begin
      failures++;
      $display("FAIL repeat_held got held=%b mods=%b required held=1 mods=0001", key_held, mods);
    end
    send_seq('{8'hF0, 8'h1C, 8'hF0, 8'h12});
    checks++;
    if ({key_held, rel_cnt} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL repeat_rel got held=%b rel=%0d required held=0 rel=2", key_held, rel_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      pop_evt(w);
      checks++;
      if (w !== exp[i]) begin
        failures++;
        $display("FAIL repeat_evt%0d got=%h required=%h", i, w, exp[i]);
      end
    end
    checks++;
    if (bus.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL repeat_drained evt_valid=%b required=0", bus.evt_valid);
    end
  endtask

  task automatic test_ext_ctrl();
    logic [14:0] w;
    logic [14:0] exp [3];
    exp = '{ev(4'h2, 1'b1, 1'b0, 8'h14), ev(4'h0, 1'b1, 1'b1, 8'h14),
            ev(4'h0, 1'b0, 1'b1, 8'h14)};
    do_reset();
    send_seq('{8'hE0, 8'h14});
    checks++;
    if (mods !== 4'b0010) begin
      failures++;
      $display("FAIL ext_ctrl_make mods=%b required=0010", mods);
    end
    send_seq('{8'hE0, 8'hF0, 8'h14, 8'hF0, 8'h14});
    for (int i = 0; i < 3; i++) begin
      pop_evt(w);
      checks++;
      if (w !== exp[i]) begin
        failures++;
        $display("FAIL ext_ctrl_evt%0d got=%h required=%h", i, w, exp[i]);
      end
    end
    // Left and right ctrl held together: releasing right alone keeps ctrl.
    send_seq('{8'h14, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14});
    checks++;
    if (mods !== 4'b0010) begin
      failures++;
      $display("FAIL ctrl_combined mods=%b required=0010", mods);
    end
    send_seq('{8'hF0, 8'h14});
    checks++;
    if (mods !== 4'b0000) begin
      failures++;
      $display("FAIL ctrl_released mods=%b required=0000", mods);
    end
  endtask

  task automatic test_caps();
    logic [14:0] w;
    logic [14:0] exp [4];
    exp = '{ev(4'h8, 1'b0, 1'b0, 8'h58), ev(4'h8, 1'b0, 1'b1, 8'h58),
            ev(4'h0, 1'b0, 1'b0, 8'h58), ev(4'h0, 1'b0, 1'b1, 8'h58)};
    do_reset();
    send_byte(8'h58);
    checks++;
    if (mods !== 4'b1000) begin
      failures++;
      $display("FAIL caps_first mods=%b required=1000", mods);
    end
    send_seq('{8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58});
    checks++;
    if (mods !== 4'b0000) begin
      failures++;
      $display("FAIL caps_second mods=%b required=0000", mods);
    end
    for (int i = 0; i < 4; i++) begin
      pop_evt(w);
      checks++;
      if (w !== exp[i]) begin
        failures++;
        $display("FAIL caps_evt%0d got=%h required=%h", i, w, exp[i]);
      end
    end
    // Auto-repeated caps make must not toggle again.
    send_seq('{8'h58, 8'h58, 8'h58});
    checks++;
    if (mods !== 4'b1000) begin
      failures++;
      $display("FAIL caps_repeat mods=%b required=1000", mods);
    end
  endtask

  task automatic test_pause();
    logic [14:0] w;
    do_reset();
    send_seq('{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    checks++;
    if ({bus.evt_valid, mods, rel_cnt} !== 13'h0) begin
      failures++;
      $display("FAIL pause_silent got v=%b mods=%b rel=%0d required all 0",
               bus.evt_valid, mods, rel_cnt);
    end
    send_byte(8'h1C);
    pop_evt(w);
    checks++;
    if (w !== ev(4'h0, 1'b0, 1'b0, 8'h1C)) begin
      failures++;
      $display("FAIL pause_after got=%h required=%h", w, ev(4'h0, 1'b0, 1'b0, 8'h1C));
    end
    checks++;
    if (bus.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL pause_drained evt_valid=%b required=0", bus.evt_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [14:0] w;
    logic [7:0]  codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(codes[i]);
    checks++;
    if ({bus.in_ready, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL full_ready got rdy=%b ovf=%b required 0 0", bus.in_ready, overflow);
    end
    bus.in_valid = 1'b1;
    bus.in_data = codes[8];
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, overflow} !== 2'b01) begin
      failures++;
      $display("FAIL full_overflow got rdy=%b ovf=%b required rdy=0 ovf=1", bus.in_ready, overflow);
    end
    bus.evt_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.evt_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refill in_ready=%b required=0", bus.in_ready);
    end
    for (int i = 1; i < 9; i++) begin
      pop_evt(w);
      checks++;
      if (w !== ev(4'h0, 1'b0, 1'b0, codes[i])) begin
        failures++;
        $display("FAIL full_evt%0d got=%h required=%h", i, w, ev(4'h0, 1'b0, 1'b0, codes[i]));
      end
    end
    checks++;
    if ({bus.evt_valid, overflow} !== 2'b01) begin
      failures++;
      $display("FAIL full_drained got v=%b ovf=%b required v=0 ovf=1", bus.evt_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] w;
    logic [7:0]  keys [9];
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    bus.evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.evt_ready = 1'b0;
    send_byte(8'h1C);
    checks++;
    if ({bus.evt_valid, bus.evt_code} !== {1'b1, 8'h1C}) begin
      failures++;
      $display("FAIL empty_pop got v=%b code=%h required v=1 code=1c", bus.evt_valid, bus.evt_code);
    end
    // One entry: push and pop on the same edge.
    bus.evt_ready = 1'b1;
    send_byte(8'h1D);
    bus.evt_ready = 1'b0;
    checks++;
    if ({bus.evt_valid, bus.evt_code} !== {1'b1, 8'h1D}) begin
      failures++;
      $display("FAIL one_pushpop got v=%b code=%h required v=1 code=1d", bus.evt_valid, bus.evt_code);
    end
    pop_evt(w);
    checks++;
    if (bus.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL one_occupancy evt_valid=%b required=0", bus.evt_valid);
    end
    // Full-1: push and pop together keeps 7 entries, one more fills.
    for (int i = 0; i < 7; i++) send_byte(keys[i]);
    bus.evt_ready = 1'b1;
    send_byte(keys[7]);
    bus.evt_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fm1_pushpop in_ready=%b required=1", bus.in_ready);
    end
    send_byte(keys[8]);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fm1_full in_ready=%b required=0", bus.in_ready);
    end
    for (int i = 1; i < 9; i++) begin
      pop_evt(w);
      checks++;
      if (w !== ev(4'h0, 1'b0, 1'b0, keys[i])) begin
        failures++;
        $display("FAIL b2b_evt%0d got=%h required=%h", i, w, ev(4'h0, 1'b0, 1'b0, keys[i]));
      end
    end
  endtask

  task automatic test_rel_wrap();
    do_reset();
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 255; i++) send_seq('{8'hF0, 8'h1C});
    checks++;
    if (rel_cnt !== 8'd255) begin
      failures++;
      $display("FAIL rel_255 got=%0d required=255", rel_cnt);
    end
    send_seq('{8'hF0, 8'h1C});
    bus.evt_ready = 1'b0;
    checks++;
    if (rel_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rel_wrap got=%0d required=0", rel_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] w;
    do_reset();
    send_seq('{8'h12, 8'h58, 8'h1C, 8'hE0});
    checks++;
    if (mods !== 4'b1001) begin
      failures++;
      $display("FAIL pre_reset mods=%b required=1001", mods);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.evt_valid, bus.in_ready, mods, key_held} !== 7'b0100000) begin
      failures++;
      $display("FAIL async_reset got v=%b rdy=%b mods=%b held=%b required v=0 rdy=1 mods=0000 held=0",
               bus.evt_valid, bus.in_ready, mods, key_held);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h14);
    pop_evt(w);
    checks++;
    if (w !== ev(4'h2, 1'b0, 1'b0, 8'h14)) begin
      failures++;
      $display("FAIL post_reset_parser got=%h required=%h", w, ev(4'h2, 1'b0, 1'b0, 8'h14));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.evt_ready = 1'b0;
    test_reset();
    test_basic();
    test_repeat_filter();
    test_ext_ctrl();
    test_caps();
    test_pause();
    test_fifo_full();
    test_back_to_back();
    test_rel_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
